// File: rtl/fp_pkg.sv
// Shared constants and FSM state type for the
// floating-point normalize/round datapath.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = 27;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        HOLD
    } state_e;

endpackage

// File: rtl/round_inc24.sv
// Combinational 24-bit incrementer for the rounding step;
// carry reports overflow out of the hidden bit.
module round_inc24
    import fp_pkg::*;
(
    input  logic [FRAC_W:0] a,
    input  logic            inc,
    output logic [FRAC_W:0] sum,
    output logic            carry
);

    logic [FRAC_W+1:0] s;

    assign s     = {1'b0, a} + {{(FRAC_W+1){1'b0}}, inc};
    assign sum   = s[FRAC_W:0];
    assign carry = s[FRAC_W+1];

endmodule

// File: rtl/fp_norm_round.sv
// Sequential normalize (one bit per cycle) and round-to-nearest-even
// stage of the single-precision adder.
module fp_norm_round
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_mark
);

    state_e              state_q, state_d;
    logic                sign_q, sign_d;
    logic [EXP_W-1:0]    exp_q, exp_d;
    logic [MANT_W-1:0]   mant_q, mant_d;
    logic                zero_q, zero_d;
    logic                inf_q, inf_d;
    logic                out_sign_q, out_sign_d;
    logic [EXP_W-1:0]    out_exp_q, out_exp_d;
    logic [FRAC_W-1:0]   out_frac_q, out_frac_d;
    logic                out_mark_q, out_mark_d;

    logic [EXP_W-1:0]    exp_inc;
    logic                round_up;
    logic [FRAC_W:0]     rnd_sum;
    logic                rnd_carry;

    assign exp_inc  = exp_q + 8'd1;
    // L = bit2, G = bit1, S = bit0
    assign round_up = mant_q[1] & (mant_q[0] | mant_q[2]);

    round_inc24 u_inc (
        .a     (mant_q[25:2]),
        .inc   (round_up),
        .sum   (rnd_sum),
        .carry (rnd_carry)
    );

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        mant_d     = mant_q;
        zero_d     = zero_q;
        inf_d      = inf_q;
        out_sign_d = out_sign_q;
        out_exp_d  = out_exp_q;
        out_frac_d = out_frac_q;
        out_mark_d = out_mark_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_sign;
                    exp_d   = in_exp;
                    mant_d  = in_mant;
                    zero_d  = 1'b0;
                    inf_d   = 1'b0;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (exp_q == EXP_MAX) begin
                    inf_d   = 1'b1;
                    state_d = ROUND;
                end else if (mant_q == '0) begin
                    zero_d  = 1'b1;
                    state_d = ROUND;
                end else if (mant_q[26]) begin
                    // shifted-out bit folds into sticky
                    mant_d  = {1'b0, mant_q[26:2], mant_q[1] | mant_q[0]};
                    exp_d   = exp_inc;
                    inf_d   = (exp_inc == EXP_MAX);
                    state_d = ROUND;
                end else if (mant_q[25]) begin
                    state_d = ROUND;
                end else if (exp_q <= 8'd1) begin
                    zero_d  = 1'b1;
                    state_d = ROUND;
                end else begin
                    mant_d = {mant_q[25:0], 1'b0};
                    exp_d  = exp_q - 8'd1;
                end
            end
            ROUND: begin
                out_sign_d = sign_q;
                out_exp_d  = exp_q;
                out_frac_d = rnd_carry ? '0 : rnd_sum[FRAC_W-1:0];
                out_mark_d = rnd_carry;
                if (zero_q) begin
                    out_exp_d  = '0;
                    out_frac_d = '0;
                    out_mark_d = 1'b0;
                end
                if (inf_q) begin
                    out_exp_d  = EXP_MAX;
                    out_frac_d = '0;
                    out_mark_d = 1'b0;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mant_q     <= '0;
            zero_q     <= 1'b0;
            inf_q      <= 1'b0;
            out_sign_q <= 1'b0;
            out_exp_q  <= '0;
            out_frac_q <= '0;
            out_mark_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            mant_q     <= mant_d;
            zero_q     <= zero_d;
            inf_q      <= inf_d;
            out_sign_q <= out_sign_d;
            out_exp_q  <= out_exp_d;
            out_frac_q <= out_frac_d;
            out_mark_q <= out_mark_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == HOLD);
    assign out_sign  = out_sign_q;
    assign out_exp   = out_exp_q;
    assign out_frac  = out_frac_q;
    assign out_mark  = out_mark_q;

endmodule
